// File: rtl/fifo_mem_ctrl_if.sv
// FIFO controller bundle: push/pop handshake, external memory port and
// status/error flags. The controller takes the slave side; the user
// (producer/consumer plus the memory model) takes the master side.
interface fifo_mem_ctrl_if #(
    parameter int DATA_WIDTH = 6,
    parameter int ADDR_WIDTH = 3
);
    // Push/pop handshake
    logic                  iPush;
    logic                  iPop;
    logic [DATA_WIDTH-1:0] iDataIn;
    logic                  iClearErr;

    // External memory write/read port (read data is combinational)
    logic                  oMemWriteEnable;
    logic [ADDR_WIDTH-1:0] oMemWriteAddress;
    logic [DATA_WIDTH-1:0] oMemDataIn;
    logic                  oMemReadEnable;
    logic [ADDR_WIDTH-1:0] oMemReadAddress;
    logic [DATA_WIDTH-1:0] iMemDataOut;

    // Pop data and status
    logic [DATA_WIDTH-1:0] oDataOut;
    logic                  oDataValid;
    logic                  oFull;
    logic                  oEmpty;
    logic                  oAlmostFull;
    logic                  oAlmostEmpty;
    logic [ADDR_WIDTH:0]   oCount;
    logic                  oOverflow;
    logic                  oUnderflow;

    modport slave (
        input  iPush, iPop, iDataIn, iClearErr, iMemDataOut,
        output oMemWriteEnable, oMemWriteAddress, oMemDataIn,
               oMemReadEnable, oMemReadAddress,
               oDataOut, oDataValid, oFull, oEmpty, oAlmostFull,
               oAlmostEmpty, oCount, oOverflow, oUnderflow
    );

    modport master (
        output iPush, iPop, iDataIn, iClearErr, iMemDataOut,
        input  oMemWriteEnable, oMemWriteAddress, oMemDataIn,
               oMemReadEnable, oMemReadAddress,
               oDataOut, oDataValid, oFull, oEmpty, oAlmostFull,
               oAlmostEmpty, oCount, oOverflow, oUnderflow
    );
endinterface

// File: rtl/fifo_mem_ctrl.sv
// Synchronous FIFO controller driving an external single-clock memory.
// Pointers carry an extra wrap bit so full/empty are decoded from registered
// pointer state. Pop data is registered (one-cycle latency).
// Optional sticky overflow/underflow flags: define FIFO_ERR_FLAGS_EN.
module fifo_mem_ctrl #(
    parameter int DATA_WIDTH      = 6,
    parameter int ADDR_WIDTH      = 3,
    parameter int ALMOST_FULL_TH  = 6,
    parameter int ALMOST_EMPTY_TH = 2
) (
    input  logic              Clock,
    input  logic              Reset,
    fifo_mem_ctrl_if.slave    bus
);
    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] AF_TH = PW'(ALMOST_FULL_TH);
    localparam logic [PW-1:0] AE_TH = PW'(ALMOST_EMPTY_TH);

    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         count;
    logic                  empty;
    logic                  full;
    logic                  push_acc;
    logic                  pop_acc;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_valid;
    logic                  overflow;
    logic                  underflow;

    // Status decode from registered pointers and count
    always_comb begin
        empty = (wr_ptr == rd_ptr);
        full  = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);
    end

    // Accept decisions; a pop frees a slot for a same-cycle push when full
    always_comb begin
        pop_acc  = !Reset && bus.iPop && !empty;
        push_acc = !Reset && bus.iPush && (!full || pop_acc);
    end

    // Pointer advance, wrapping naturally across the extra wrap bit
    always_ff @(posedge Clock) begin
        if (Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_acc) wr_ptr <= wr_ptr + 1'b1;
            if (pop_acc)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Occupancy counter: net change of accepted push and pop
    always_ff @(posedge Clock) begin
        if (Reset) begin
            count <= '0;
        end else begin
            unique case ({push_acc, pop_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Pop data register: capture memory read data on an accepted pop
    always_ff @(posedge Clock) begin
        if (Reset) begin
            data_out   <= '0;
            data_valid <= 1'b0;
        end else begin
            data_valid <= pop_acc;
            if (pop_acc) data_out <= bus.iMemDataOut;
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    logic ovf_set;
    logic unf_set;

    // Error events: push dropped while full, pop refused while empty
    always_comb begin
        ovf_set = !Reset && bus.iPush && !push_acc;
        unf_set = !Reset && bus.iPop && empty;
    end

    // Sticky error flags; a new event wins over a same-cycle clear
    always_ff @(posedge Clock) begin
        if (Reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (ovf_set)            overflow <= 1'b1;
            else if (bus.iClearErr) overflow <= 1'b0;
            if (unf_set)            underflow <= 1'b1;
            else if (bus.iClearErr) underflow <= 1'b0;
        end
    end
`else
    logic unused_clear_err;

    assign unused_clear_err = bus.iClearErr;
    assign overflow         = 1'b0;
    assign underflow        = 1'b0;
`endif

    // Memory port and status outputs
    assign bus.oMemWriteEnable  = push_acc;
    assign bus.oMemWriteAddress = wr_ptr[ADDR_WIDTH-1:0];
    assign bus.oMemDataIn       = bus.iDataIn;
    assign bus.oMemReadEnable   = pop_acc;
    assign bus.oMemReadAddress  = rd_ptr[ADDR_WIDTH-1:0];
    assign bus.oDataOut         = data_out;
    assign bus.oDataValid       = data_valid;
    assign bus.oFull            = full;
    assign bus.oEmpty           = empty;
    assign bus.oAlmostFull      = (count >= AF_TH);
    assign bus.oAlmostEmpty     = (count <= AE_TH);
    assign bus.oCount           = count;
    assign bus.oOverflow        = overflow;
    assign bus.oUnderflow       = underflow;

endmodule
